// File: rtl/disp_pixel_fetch.sv
// Pixel fetch stage: reads one word per active DE cycle from a bottom-up frame buffer and
// re-times hsync/vsync/de to match. Define DISP_FETCH_PATTERN_EN for the colour-bar source.
module disp_pixel_fetch #(
  parameter int HRES      = 4,
  parameter int VRES      = 4,
  parameter int RD_LAT    = 1,
  parameter int AW        = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic          i_clk,
  input  logic          rst_n,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
`ifdef DISP_FETCH_PATTERN_EN
  input  logic          i_pat_en,
`endif
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [23:0]   i_rd_data,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [23:0]   o_rgb,
  output logic          o_frame_err,
  output logic          o_frame_done
);

  localparam int L  = RD_LAT + 2;
  localparam int XW = ($clog2(HRES + 1) > 3) ? $clog2(HRES + 1) : 3;
  localparam int YW = $clog2(VRES + 1);

  localparam logic [AW-1:0] TOP_ROW  = AW'(BASE_ADDR + (VRES - 1) * HRES);
  localparam logic [AW-1:0] ROW_STEP = AW'(HRES);
  localparam logic [XW-1:0] X_END    = XW'(HRES);
  localparam logic [YW-1:0] Y_END    = YW'(VRES);
  localparam logic [YW-1:0] Y_LAST   = YW'(VRES - 1);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d, de_q, de_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            frame_err_q, frame_err_d;
  logic            frame_done_q, frame_done_d;
  logic [RD_LAT:0] slot_q, slot_d;
  logic [L-1:0]    hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, de_pipe_q, de_pipe_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            vs_rise, de_fall, in_frame, issue;
`ifdef DISP_FETCH_PATTERN_EN
  logic            pat_q, pat_d;
  logic [2:0]      xp_q [RD_LAT+1];
  logic [2:0]      xp_d [RD_LAT+1];

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction
`endif

  assign vs_rise = i_vsync & ~vsync_q;
  assign de_fall = ~i_de & de_q;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Once a frame has started, only reset returns the block to idle.
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = S_FRAME;
  end

  always_comb begin
    in_frame = (state_q == S_FRAME);
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    vsync_d      = i_vsync;
    de_d         = i_de;
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    frame_err_d  = frame_err_q;
    frame_done_d = 1'b0;
    issue        = 1'b0;
`ifdef DISP_FETCH_PATTERN_EN
    pat_d        = pat_q;
`endif
    if (vs_rise) begin
      x_d         = '0;
      y_d         = '0;
      row_base_d  = TOP_ROW;
      frame_err_d = 1'b0;
`ifdef DISP_FETCH_PATTERN_EN
      pat_d       = i_pat_en;
`endif
    end else if (in_frame) begin
      if (i_de) begin
        if (y_q == Y_END || x_q == X_END) begin
          frame_err_d = 1'b1;
        end else begin
          issue = 1'b1;
          x_d   = x_q + 1'b1;
        end
      end else if (de_fall) begin
        if (x_q != X_END) frame_err_d = 1'b1;
        x_d = '0;
        // Last row stays put so the base never wraps below the bottom image row.
        if (y_q != Y_END) begin
          y_d = y_q + 1'b1;
          if (y_q == Y_LAST) frame_done_d = 1'b1;
          else               row_base_d   = row_base_q - ROW_STEP;
        end
      end
    end
  end

  always_comb begin
`ifdef DISP_FETCH_PATTERN_EN
    rd_en_d = issue & ~pat_q;
    xp_d[0] = x_q[2:0];
    for (int k = 1; k <= RD_LAT; k++) xp_d[k] = xp_q[k-1];
`else
    rd_en_d = issue;
`endif
    rd_addr_d = rd_en_d ? row_base_q + AW'(x_q) : '0;
    slot_d    = {slot_q[RD_LAT-1:0], issue};
    hs_pipe_d = {hs_pipe_q[L-2:0], i_hsync};
    vs_pipe_d = {vs_pipe_q[L-2:0], i_vsync};
    de_pipe_d = {de_pipe_q[L-2:0], i_de & in_frame};
    rgb_d     = '0;
    // Slot bit and de bit both refer to the cycle whose read data is arriving now.
    if (slot_q[RD_LAT] && de_pipe_q[RD_LAT]) begin
`ifdef DISP_FETCH_PATTERN_EN
      rgb_d = pat_q ? bar_rgb(xp_q[RD_LAT]) : i_rd_data;
`else
      rgb_d = i_rd_data;
`endif
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
  // NOTE: the short delay lines are reset too, so outputs read 0 straight after reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= TOP_ROW;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      slot_q       <= '0;
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      de_pipe_q    <= '0;
      rgb_q        <= '0;
`ifdef DISP_FETCH_PATTERN_EN
      pat_q        <= 1'b0;
      for (int k = 0; k <= RD_LAT; k++) xp_q[k] <= '0;
`endif
    end else begin
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
      slot_q       <= slot_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      de_pipe_q    <= de_pipe_d;
      rgb_q        <= rgb_d;
`ifdef DISP_FETCH_PATTERN_EN
      pat_q        <= pat_d;
      for (int k = 0; k <= RD_LAT; k++) xp_q[k] <= xp_d[k];
`endif
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_hsync      = hs_pipe_q[L-1];
  assign o_vsync      = vs_pipe_q[L-1];
  assign o_de         = de_pipe_q[L-1];
  assign o_rgb        = rgb_q;
  assign o_frame_err  = frame_err_q;
  assign o_frame_done = frame_done_q;

endmodule
